shm_client: RTL and testbench
=============================

SHM_CLIENT -- requirements
Module: shm_client

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, meaning data word width.
REQ-002 SHALL have parameter SIZE, default 16, meaning shared-memory address width.
REQ-003 SHALL have parameter PAGE_SIZE, default 4, meaning in-page offset width; PAGES_COUNT = SIZE-PAGE_SIZE is the page pointer width (12 by default).
REQ-004 SHALL have parameter RD_LAT, default 2, range 1..15, meaning cycles from grant to valid shm_data_out.
REQ-005 SHALL have parameter TIMEOUT, default 255, range 1..255, meaning maximum cycles waiting for grant.
REQ-006 clock  in  1  single clock; all logic on its rising edge.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 cmd_valid  in  1  processor command present.
REQ-009 cmd_ready  out  1  block accepts command this cycle.
REQ-010 cmd_action  in  2  0 READ, 1 WRITE, 2 ALLOC, 3 FREE.
REQ-011 cmd_ptr  in  PAGES_COUNT  page pointer.
REQ-012 cmd_shift  in  SIZE  offset within page.
REQ-013 cmd_data  in  WORD_SIZE  write data.
REQ-014 rsp_valid  out  1  response present.
REQ-015 rsp_ready  in  1  processor takes response.
REQ-016 rsp_data  out  WORD_SIZE  read word or allocated pointer (zero-extended).
REQ-017 rsp_err  out  1  response is an error (bad shift or timeout).
REQ-018 shm_req  out  1  request to shared memory.
REQ-019 shm_gnt  in  1  shared memory accepts request this cycle.
REQ-020 shm_action, shm_ptr, shm_shift, shm_data_in  out  2/PAGES_COUNT/SIZE/WORD_SIZE  request fields.
REQ-021 shm_data_out  in  WORD_SIZE  shared-memory result.

Function
REQ-022 SHALL implement FSM states IDLE, REQ, WAIT, RESP; cmd_ready=1 only in IDLE.
REQ-023 IDLE: on cmd_valid, SHALL register action/ptr/shift/data; if cmd_shift[SIZE-1:PAGE_SIZE]!=0 go to RESP with rsp_err=1, rsp_data=0, no shm_req; else go to REQ.
REQ-024 REQ: shm_req=1 and shm_* fields SHALL hold the registered values, stable until the grant cycle inclusive.
REQ-025 REQ with shm_gnt=1: WRITE/FREE SHALL go to RESP with rsp_data=0, rsp_err=0; READ/ALLOC SHALL go to WAIT with latency counter loaded to RD_LAT.
REQ-026 REQ: timeout counter SHALL increment each cycle without grant; after TIMEOUT non-granted cycles, go to RESP with rsp_err=1, rsp_data=0, shm_req deasserted; a grant in the same cycle as expiry takes precedence over timeout.
REQ-027 WAIT: counter SHALL decrement each cycle; shm_data_out SHALL be captured into rsp_data exactly RD_LAT cycles after the grant edge, then go to RESP.
REQ-028 ALLOC result SHALL be shm_data_out[PAGES_COUNT-1:0] zero-extended to WORD_SIZE.
REQ-029 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready=1; that cycle return to IDLE.
REQ-030 shm_req SHALL be 0 in all states except REQ; shm_* fields SHALL hold last values when not requesting.
REQ-031 Exactly one outstanding command; cmd_valid in non-IDLE states SHALL be ignored.
REQ-032 Minimum latency cmd accept -> rsp_valid: WRITE 2 cycles with immediate grant; READ 2+RD_LAT cycles.

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, shm_req=0, all shm_* fields 0, counters 0.
REQ-034 Reset asserted mid-transaction SHALL abort it; no response is produced after release.

Verification
REQ-035 WRITE ptr=0x005, shift=0x3, data=0xBEEF, gnt immediate -> shm_req 1 cycle with those fields, rsp_valid 2 cycles after accept, rsp_data=0, rsp_err=0.
REQ-036 READ ptr=0x005, shift=0x3, RD_LAT=2, shm_data_out=0xBEEF 2 cycles after grant -> rsp_data=0xBEEF, rsp_err=0.
REQ-037 ALLOC, shm_data_out=0xF123 -> rsp_data=0x0123.
REQ-038 READ with shift=0x0010 -> no shm_req, rsp_valid with rsp_err=1, rsp_data=0.
REQ-039 shm_gnt held 0, TIMEOUT=4 -> shm_req high 4 cycles, then rsp_err=1; grant on 4th cycle instead -> normal completion.
REQ-040 reset_n pulsed low during WAIT, rsp_ready held 0 in RESP for 3 cycles -> outputs at reset values immediately; response held stable 3 cycles then IDLE.

Source files
------------

// File: rtl/shm_client.sv
// shm_client: single-outstanding processor command client for a paged shared memory
module shm_client #(
    parameter int WORD_SIZE = 16,
    parameter int SIZE = 16,
    parameter int PAGE_SIZE = 4,
    parameter int RD_LAT = 2,
    parameter int TIMEOUT = 255,
    localparam int PAGES_COUNT = SIZE - PAGE_SIZE
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_action,
    input  logic [PAGES_COUNT-1:0] cmd_ptr,
    input  logic [SIZE-1:0]        cmd_shift,
    input  logic [WORD_SIZE-1:0]   cmd_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORD_SIZE-1:0]   rsp_data,
    output logic                   rsp_err,
    output logic                   shm_req,
    input  logic                   shm_gnt,
    output logic [1:0]             shm_action,
    output logic [PAGES_COUNT-1:0] shm_ptr,
    output logic [SIZE-1:0]        shm_shift,
    output logic [WORD_SIZE-1:0]   shm_data_in,
    input  logic [WORD_SIZE-1:0]   shm_data_out
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    localparam logic [1:0] A_READ = 2'd0;
    localparam logic [1:0] A_ALLOC = 2'd2;
    state_t                   state, state_nx;
    logic [1:0]               act_nx;
    logic [PAGES_COUNT-1:0]   ptr_nx;
    logic [SIZE-1:0]          shift_nx;
    logic [WORD_SIZE-1:0]     din_nx, rdata_nx;
    logic                     rerr_nx;
    logic [3:0]               lat_cnt, lat_nx;
    logic [7:0]               to_cnt, to_nx;
    logic                     bad_shift, is_rd;
    assign cmd_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign shm_req   = state == REQ;
    assign bad_shift = cmd_shift[SIZE-1:PAGE_SIZE] != '0;
    assign is_rd     = shm_action == A_READ || shm_action == A_ALLOC;
    // state and datapath registers; request fields only change when a new request is issued
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shm_action  <= '0;
            shm_ptr     <= '0;
            shm_shift   <= '0;
            shm_data_in <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            lat_cnt     <= '0;
            to_cnt      <= '0;
        end else begin
            state       <= state_nx;
            shm_action  <= act_nx;
            shm_ptr     <= ptr_nx;
            shm_shift   <= shift_nx;
            shm_data_in <= din_nx;
            rsp_data    <= rdata_nx;
            rsp_err     <= rerr_nx;
            lat_cnt     <= lat_nx;
            to_cnt      <= to_nx;
        end
    end
    // next-state: accept, arbitrate with grant/timeout (grant wins on expiry), wait read latency, respond
    always_comb begin
        state_nx = state;
        act_nx   = shm_action;
        ptr_nx   = shm_ptr;
        shift_nx = shm_shift;
        din_nx   = shm_data_in;
        rdata_nx = rsp_data;
        rerr_nx  = rsp_err;
        lat_nx   = lat_cnt;
        to_nx    = to_cnt;
        case (state)
            IDLE: if (cmd_valid) begin
                if (bad_shift) begin
                    state_nx = RESP;
                    rdata_nx = '0;
                    rerr_nx  = 1'b1;
                end else begin
                    state_nx = REQ;
                    act_nx   = cmd_action;
                    ptr_nx   = cmd_ptr;
                    shift_nx = cmd_shift;
                    din_nx   = cmd_data;
                    to_nx    = '0;
                end
            end
            REQ: if (shm_gnt) begin
                state_nx = is_rd ? WAIT : RESP;
                lat_nx   = 4'(RD_LAT);
                rdata_nx = '0;
                rerr_nx  = 1'b0;
            end else if (to_cnt == 8'(TIMEOUT - 1)) begin
                state_nx = RESP;
                rdata_nx = '0;
                rerr_nx  = 1'b1;
                to_nx    = '0;
            end else begin
                to_nx = to_cnt + 8'd1;
            end
            WAIT: begin
                lat_nx = lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    state_nx = RESP;
                    rerr_nx  = 1'b0;
                    rdata_nx = shm_action == A_ALLOC ? WORD_SIZE'(shm_data_out[PAGES_COUNT-1:0]) : shm_data_out;
                end
            end
            RESP: if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_shm_client.sv
// tb_shm_client: randomized and directed checks of shm_client against a transaction-level model
module tb_shm_client;
    localparam int RD_LAT = 2;
    localparam int TIMEOUT = 4;
    localparam logic [1:0] A_READ = 2'd0, A_WRITE = 2'd1, A_ALLOC = 2'd2, A_FREE = 2'd3;
    logic        clock = 1'b0, reset_n;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, shm_req, shm_gnt;
    logic [1:0]  cmd_action, shm_action;
    logic [11:0] cmd_ptr, shm_ptr;
    logic [15:0] cmd_shift, cmd_data, rsp_data, shm_shift, shm_data_in, shm_data_out;
    int          checks = 0, failures = 0;
    int          o_lat, o_reqcnt;
    logic [15:0] o_data;
    logic        o_err, o_fieldbad, o_holdbad, o_busy, o_idle, o_ready0;

    shm_client #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_action(cmd_action), .cmd_ptr(cmd_ptr), .cmd_shift(cmd_shift), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .shm_req(shm_req), .shm_gnt(shm_gnt), .shm_action(shm_action), .shm_ptr(shm_ptr),
        .shm_shift(shm_shift), .shm_data_in(shm_data_in), .shm_data_out(shm_data_out)
    );

    always #5 clock = ~clock;

    // Expected outcome of one command from the memory protocol rules:
    // g = number of requesting cycles that pass without grant before grant.
    function automatic void model(input logic [1:0] a, input logic [15:0] s, input logic [15:0] rw, input int g,
                                  output int lat, output int reqs, output logic [15:0] data, output logic err);
        if (s[15:4] != 12'h0) begin
            lat = 1; reqs = 0; data = 16'h0; err = 1'b1;
        end else if (g >= TIMEOUT) begin
            lat = TIMEOUT + 1; reqs = TIMEOUT; data = 16'h0; err = 1'b1;
        end else begin
            reqs = g + 1;
            err  = 1'b0;
            lat  = 2 + g + ((a == A_READ || a == A_ALLOC) ? RD_LAT : 0);
            data = a == A_READ ? rw : a == A_ALLOC ? {4'h0, rw[11:0]} : 16'h0;
        end
    endfunction

    // Drives one command, acts as the shared memory, and records what the DUT did.
    task automatic do_txn(input logic [1:0] a, input logic [11:0] p, input logic [15:0] s, input logic [15:0] d,
                          input int g, input logic [15:0] rw, input int hold);
        int  tg;
        bit  done;
        tg = -1000; done = 0;
        o_lat = -1; o_reqcnt = 0; o_data = 16'hxxxx; o_err = 1'bx;
        o_fieldbad = 0; o_holdbad = 0; o_busy = 0; o_idle = 0;
        @(negedge clock);
        o_ready0 = cmd_ready;
        cmd_valid = 1; cmd_action = a; cmd_ptr = p; cmd_shift = s; cmd_data = d;
        rsp_ready = 0; shm_gnt = 0;
        for (int t = 1; t < 80 && !done; t++) begin
            @(negedge clock);
            cmd_valid = 1'($urandom); cmd_action = 2'($urandom); cmd_ptr = 12'($urandom);
            cmd_shift = 16'($urandom); cmd_data = 16'($urandom);
            shm_gnt = 0;
            if (cmd_ready) o_busy = 1;
            if (shm_req) begin
                if (shm_action !== a || shm_ptr !== p || shm_shift !== s || shm_data_in !== d) o_fieldbad = 1;
                if (o_reqcnt == g) begin shm_gnt = 1; tg = t; end
                o_reqcnt++;
            end
            shm_data_out = (t == tg + RD_LAT) ? rw : ~rw;
            if (rsp_valid) begin
                o_lat = t; o_data = rsp_data; o_err = rsp_err; o_busy = 0;
                if (shm_req) o_fieldbad = 1;
                cmd_valid = 0;
                repeat (hold) begin
                    @(negedge clock);
                    if (!rsp_valid || rsp_data !== o_data || rsp_err !== o_err || cmd_ready || shm_req) o_holdbad = 1;
                end
                rsp_ready = 1;
                @(negedge clock);
                rsp_ready = 0;
                o_idle = cmd_ready && !rsp_valid && !shm_req;
                done = 1;
            end
        end
        if (!done) begin
            cmd_valid = 0; reset_n = 0;
            @(negedge clock);
            reset_n = 1;
        end
    endtask

    task automatic test_reset;
        reset_n = 0; cmd_valid = 0; cmd_action = 0; cmd_ptr = 0; cmd_shift = 0; cmd_data = 0;
        rsp_ready = 0; shm_gnt = 0; shm_data_out = 0;
        repeat (2) @(negedge clock);
        checks++;
        if (cmd_ready !== 1 || rsp_valid !== 0 || rsp_err !== 0 || rsp_data !== 0 || shm_req !== 0)
            begin failures++; $display("FAIL reset_outputs: ready=%b valid=%b err=%b data=%h req=%b, want 1 0 0 0000 0", cmd_ready, rsp_valid, rsp_err, rsp_data, shm_req); end
        checks++;
        if (shm_action !== 0 || shm_ptr !== 0 || shm_shift !== 0 || shm_data_in !== 0)
            begin failures++; $display("FAIL reset_fields: act=%h ptr=%h shift=%h din=%h, want all 0", shm_action, shm_ptr, shm_shift, shm_data_in); end
        reset_n = 1;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1 || rsp_valid !== 0 || shm_req !== 0)
            begin failures++; $display("FAIL after_reset_idle: ready=%b valid=%b req=%b, want 1 0 0", cmd_ready, rsp_valid, shm_req); end
    endtask

    task automatic test_write;
        do_txn(A_WRITE, 12'h005, 16'h0003, 16'hBEEF, 0, 16'h1234, 0);
        checks++;
        if (o_lat !== 2 || o_reqcnt !== 1) begin failures++; $display("FAIL write_timing: lat=%0d reqs=%0d, want 2 1", o_lat, o_reqcnt); end
        checks++;
        if (o_fieldbad !== 0 || o_ready0 !== 1) begin failures++; $display("FAIL write_fields: fieldbad=%b ready=%b, want 0 1", o_fieldbad, o_ready0); end
        checks++;
        if (o_data !== 16'h0 || o_err !== 0 || o_idle !== 1) begin failures++; $display("FAIL write_rsp: data=%h err=%b idle=%b, want 0000 0 1", o_data, o_err, o_idle); end
    endtask

    task automatic test_read;
        do_txn(A_READ, 12'h005, 16'h0003, 16'h0000, 0, 16'hBEEF, 0);
        checks++;
        if (o_lat !== 2 + RD_LAT || o_reqcnt !== 1) begin failures++; $display("FAIL read_timing: lat=%0d reqs=%0d, want %0d 1", o_lat, o_reqcnt, 2 + RD_LAT); end
        checks++;
        if (o_data !== 16'hBEEF || o_err !== 0 || o_fieldbad !== 0) begin failures++; $display("FAIL read_rsp: data=%h err=%b fieldbad=%b, want beef 0 0", o_data, o_err, o_fieldbad); end
    endtask

    task automatic test_alloc;
        do_txn(A_ALLOC, 12'h000, 16'h0000, 16'h0000, 1, 16'hF123, 0);
        checks++;
        if (o_data !== 16'h0123 || o_err !== 0 || o_lat !== 3 + RD_LAT) begin failures++; $display("FAIL alloc_rsp: data=%h err=%b lat=%0d, want 0123 0 %0d", o_data, o_err, o_lat, 3 + RD_LAT); end
    endtask

    task automatic test_bad_shift;
        do_txn(A_READ, 12'h005, 16'h0010, 16'h0000, 0, 16'hBEEF, 0);
        checks++;
        if (o_reqcnt !== 0 || o_lat !== 1) begin failures++; $display("FAIL bad_shift_timing: reqs=%0d lat=%0d, want 0 1", o_reqcnt, o_lat); end
        checks++;
        if (o_data !== 16'h0 || o_err !== 1 || o_idle !== 1) begin failures++; $display("FAIL bad_shift_rsp: data=%h err=%b idle=%b, want 0000 1 1", o_data, o_err, o_idle); end
    endtask

    task automatic test_timeout;
        do_txn(A_WRITE, 12'hABC, 16'h000F, 16'h5555, 100, 16'h0, 0);
        checks++;
        if (o_reqcnt !== TIMEOUT || o_lat !== TIMEOUT + 1) begin failures++; $display("FAIL timeout_timing: reqs=%0d lat=%0d, want %0d %0d", o_reqcnt, o_lat, TIMEOUT, TIMEOUT + 1); end
        checks++;
        if (o_err !== 1 || o_data !== 16'h0) begin failures++; $display("FAIL timeout_rsp: err=%b data=%h, want 1 0000", o_err, o_data); end
        do_txn(A_READ, 12'h00F, 16'h0001, 16'h0, TIMEOUT - 1, 16'h7E57, 0);
        checks++;
        if (o_reqcnt !== TIMEOUT || o_err !== 0 || o_data !== 16'h7E57 || o_lat !== 1 + TIMEOUT + RD_LAT)
            begin failures++; $display("FAIL late_grant: reqs=%0d err=%b data=%h lat=%0d, want %0d 0 7e57 %0d", o_reqcnt, o_err, o_data, o_lat, TIMEOUT, 1 + TIMEOUT + RD_LAT); end
    endtask

    task automatic test_reset_mid;
        bit stray;
        @(negedge clock);
        cmd_valid = 1; cmd_action = A_READ; cmd_ptr = 12'h321; cmd_shift = 16'h0007; cmd_data = 16'h0;
        @(negedge clock);
        cmd_valid = 0; shm_gnt = 1;
        checks++;
        if (shm_req !== 1) begin failures++; $display("FAIL mid_req: req=%b, want 1", shm_req); end
        @(negedge clock);
        shm_gnt = 0;
        #2 reset_n = 0;
        #1;
        checks++;
        if (cmd_ready !== 1 || rsp_valid !== 0 || rsp_err !== 0 || rsp_data !== 0 || shm_req !== 0 ||
            shm_action !== 0 || shm_ptr !== 0 || shm_shift !== 0 || shm_data_in !== 0)
            begin failures++; $display("FAIL async_reset: ready=%b valid=%b req=%b ptr=%h shift=%h, want 1 0 0 000 0000", cmd_ready, rsp_valid, shm_req, shm_ptr, shm_shift); end
        @(negedge clock);
        reset_n = 1;
        stray = 0;
        repeat (8) begin
            @(negedge clock);
            shm_data_out = 16'($urandom);
            if (rsp_valid || shm_req || !cmd_ready) stray = 1;
        end
        checks++;
        if (stray) begin failures++; $display("FAIL abort_no_rsp: activity after reset release, want none"); end
    endtask

    task automatic test_resp_hold;
        do_txn(A_READ, 12'h0AA, 16'h0002, 16'h0, 0, 16'hC0DE, 3);
        checks++;
        if (o_holdbad !== 0 || o_data !== 16'hC0DE || o_err !== 0) begin failures++; $display("FAIL resp_hold: holdbad=%b data=%h err=%b, want 0 c0de 0", o_holdbad, o_data, o_err); end
        checks++;
        if (o_idle !== 1) begin failures++; $display("FAIL resp_release: idle=%b, want 1", o_idle); end
    endtask

    task automatic test_random;
        logic [1:0]  a;
        logic [11:0] p;
        logic [15:0] s, d, rw, e_data;
        int          g, h, e_lat, e_reqs;
        logic        e_err;
        for (int i = 0; i < 40; i++) begin
            a = 2'($urandom); p = 12'($urandom); d = 16'($urandom); rw = 16'($urandom);
            s = ($urandom_range(5) == 0) ? (16'($urandom) | 16'h0010) : 16'($urandom_range(15));
            g = $urandom_range(TIMEOUT + 1);
            h = $urandom_range(3);
            model(a, s, rw, g, e_lat, e_reqs, e_data, e_err);
            do_txn(a, p, s, d, g, rw, h);
            checks++;
            if (o_lat !== e_lat || o_reqcnt !== e_reqs) begin failures++; $display("FAIL rnd_timing[%0d]: act=%0d lat=%0d reqs=%0d, want %0d %0d", i, a, o_lat, o_reqcnt, e_lat, e_reqs); end
            checks++;
            if (o_data !== e_data || o_err !== e_err) begin failures++; $display("FAIL rnd_rsp[%0d]: act=%0d data=%h err=%b, want %h %b", i, a, o_data, o_err, e_data, e_err); end
            checks++;
            if (o_fieldbad || o_holdbad || o_busy || !o_idle || !o_ready0)
                begin failures++; $display("FAIL rnd_proto[%0d]: fieldbad=%b holdbad=%b busy=%b idle=%b ready=%b, want 0 0 0 1 1", i, o_fieldbad, o_holdbad, o_busy, o_idle, o_ready0); end
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_alloc;
        test_bad_shift;
        test_timeout;
        test_reset_mid;
        test_resp_hold;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
